// File: rtl/dbn_pkg.sv
// Shared types and helpers for the DBN hidden-layer datapath.
// Q8.8 operands, Q16.16 accumulators, saturating add.
package dbn_pkg;

  localparam int DW    = 16;
  localparam int AW    = 32;
  localparam int LANES = 16;

  typedef logic signed [DW-1:0] fix16_t;
  typedef logic signed [AW-1:0] fix32_t;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  // One guard bit catches signed overflow; clamp to the rail it ran past.
  function automatic fix32_t sat_add32(
    input fix32_t a,
    input fix32_t b
  );
    logic signed [AW:0] s;
    s = {a[AW-1], a} + {b[AW-1], b};
    if (s[AW] != s[AW-1])
      sat_add32 = s[AW] ? {1'b1, {(AW-1){1'b0}}}
                        : {1'b0, {(AW-1){1'b1}}};
    else
      sat_add32 = s[AW-1:0];
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One hidden-unit lane: exact Q8.8 x Q8.8 product
// added into a saturating Q16.16 accumulator.
module mac_lane
  import dbn_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clr_load,
  input  fix32_t bias,
  input  logic   en,
  input  fix16_t vis,
  input  fix16_t w,
  output fix32_t acc
);

  fix32_t prod;

  assign prod = fix32_t'(vis) * fix32_t'(w);

  // Preload bias at pass start, then accumulate accepted beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (clr_load)
      acc <= bias;
    else if (en)
      acc <= sat_add32(acc, prod);
  end

endmodule

// File: rtl/mac_accum_16.sv
// 16-lane MAC stage: pass FSM, beat counter and lane packing.
// Sums are held on sum_output until the next accepted start.
module mac_accum_16
  import dbn_pkg::*;
#(
  parameter int N_VIS = 784,
  localparam int CNT_W = $clog2(N_VIS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LANES*AW-1:0] bias_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       vis_in,
  input  logic [LANES*DW-1:0] weight_in,
  output logic                sum_valid,
  input  logic                sum_ready,
  output logic [LANES*AW-1:0] sum_output,
  output logic                busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_VIS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             clr_load;
  logic             en;

  assign clr_load = (state == IDLE) & start;
  assign en       = in_ready & in_valid;

  // Pass sequencing; handshake outputs are registered with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      sum_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state    <= ACC;
          cnt      <= '0;
          in_ready <= 1'b1;
          busy     <= 1'b1;
        end
        ACC: if (in_valid) begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            in_ready  <= 1'b0;
            sum_valid <= 1'b1;
          end
        end
        DONE: if (sum_ready) begin
          state     <= IDLE;
          sum_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          sum_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr_load (clr_load),
      .bias     (bias_in[i*AW +: AW]),
      .en       (en),
      .vis      (vis_in),
      .w        (weight_in[i*DW +: DW]),
      .acc      (sum_output[i*AW +: AW])
    );
  end

endmodule
